// File: rtl/vram_arbiter.sv
// Three-way arbiter (video scan-out, CPU, screen-clear) in front of one single-port 128x64x2 VRAM.
// Define VRAM_ARB_CLEAR_EN to build the clear engine; otherwise clr_busy is tied low.
module vram_arbiter #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vid_req,
   input  logic [6:0]  vid_hpos,
   input  logic [5:0]  vid_vpos,
   output logic [1:0]  vid_pixel,
   output logic        vid_valid,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [6:0]  cpu_hpos,
   input  logic [5:0]  cpu_vpos,
   input  logic [1:0]  cpu_pixeli,
   output logic [1:0]  cpu_pixelo,
   output logic        cpu_ack,
   input  logic        clr_start,
   input  logic [1:0]  clr_value,
   output logic        clr_busy,
   output logic [12:0] mem_addr,
   output logic        mem_we,
   output logic [1:0]  mem_din,
   input  logic [1:0]  mem_dout
);

   // Bit 0 set at the grant edge, bit 1 one edge later; either bit means outstanding.
   logic [1:0]  vid_pipe, cpu_pipe, cpu_rd_pipe;
   logic [3:0]  starve_cnt;
   logic        vid_elig, cpu_elig;
   logic        gnt_vid, gnt_cpu, gnt_clr;
   logic [12:0] clr_addr;
   logic [1:0]  clr_val;

`ifdef VRAM_ARB_CLEAR_EN
   typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_t;
   clr_state_t  clr_state, clr_state_nxt;
   logic [12:0] clr_addr_nxt;
   logic [1:0]  clr_val_nxt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         clr_state <= CLR_IDLE;
         clr_addr  <= '0;
         clr_val   <= '0;
      end else begin
         clr_state <= clr_state_nxt;
         clr_addr  <= clr_addr_nxt;
         clr_val   <= clr_val_nxt;
      end
   end

   always_comb begin
      clr_state_nxt = clr_state;
      clr_addr_nxt  = clr_addr;
      clr_val_nxt   = clr_val;
      case (clr_state)
         CLR_IDLE: if (clr_start) begin
            clr_val_nxt   = clr_value;
            clr_addr_nxt  = '0;
            clr_state_nxt = CLR_SWEEP;
         end
         CLR_SWEEP: if (gnt_clr) begin
            clr_addr_nxt = clr_addr + 13'd1;
            if (clr_addr == 13'h1fff) clr_state_nxt = CLR_IDLE;
         end
         default: clr_state_nxt = CLR_IDLE;
      endcase
   end

   assign clr_busy = (clr_state == CLR_SWEEP);
`else
   logic unused_clr;
   assign unused_clr = ^{clr_start, clr_value};
   assign clr_busy   = 1'b0;
   assign clr_addr   = '0;
   assign clr_val    = '0;
`endif

   assign vid_elig = vid_req & ~|vid_pipe;
   assign cpu_elig = cpu_req & ~|cpu_pipe & ~clr_busy;
   assign gnt_cpu  = cpu_elig & ((starve_cnt == 4'(STARVE_LIMIT)) | ~vid_elig);
   assign gnt_vid  = vid_elig & ~gnt_cpu;
   assign gnt_clr  = clr_busy & ~gnt_cpu & ~gnt_vid;

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_din     <= '0;
         vid_pipe    <= '0;
         cpu_pipe    <= '0;
         cpu_rd_pipe <= '0;
         vid_valid   <= 1'b0;
         vid_pixel   <= '0;
         cpu_ack     <= 1'b0;
         cpu_pixelo  <= '0;
         starve_cnt  <= '0;
      end else begin
         mem_we <= 1'b0;
         if (gnt_vid) begin
            mem_addr <= {vid_vpos, vid_hpos};
         end else if (gnt_cpu) begin
            mem_addr <= {cpu_vpos, cpu_hpos};
            mem_we   <= cpu_we;
            mem_din  <= cpu_pixeli;
         end else if (gnt_clr) begin
            mem_addr <= clr_addr;
            mem_we   <= 1'b1;
            mem_din  <= clr_val;
         end

         vid_pipe    <= {vid_pipe[0], gnt_vid};
         cpu_pipe    <= {cpu_pipe[0], gnt_cpu};
         cpu_rd_pipe <= {cpu_rd_pipe[0], gnt_cpu & ~cpu_we};

         // VRAM output for a grant at N is stable at N+2; completions land there.
         vid_valid <= vid_pipe[1];
         if (vid_pipe[1]) vid_pixel <= mem_dout;
         cpu_ack   <= cpu_pipe[1];
         if (cpu_rd_pipe[1]) cpu_pixelo <= mem_dout;

         if (cpu_elig && gnt_vid) starve_cnt <= starve_cnt + 4'd1;
         else                     starve_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port VRAM (preloaded with addr[1:0]).
module tb_vram_arbiter;

   logic        clk, reset;
   logic        vid_req, vid_valid;
   logic [6:0]  vid_hpos;
   logic [5:0]  vid_vpos;
   logic [1:0]  vid_pixel;
   logic        cpu_req, cpu_we, cpu_ack;
   logic [6:0]  cpu_hpos;
   logic [5:0]  cpu_vpos;
   logic [1:0]  cpu_pixeli, cpu_pixelo;
   logic        clr_start, clr_busy;
   logic [1:0]  clr_value;
   logic [12:0] mem_addr;
   logic        mem_we;
   logic [1:0]  mem_din, mem_dout;

   logic [1:0]  ram [0:8191];
   logic        ram_fill;
   int          nchk, npass;

   vram_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_hpos(vid_hpos), .vid_vpos(vid_vpos),
      .vid_pixel(vid_pixel), .vid_valid(vid_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_hpos(cpu_hpos), .cpu_vpos(cpu_vpos),
      .cpu_pixeli(cpu_pixeli), .cpu_pixelo(cpu_pixelo), .cpu_ack(cpu_ack),
      .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (ram_fill) begin
         for (int i = 0; i < 8192; i++) ram[i] <= i[1:0];
      end else if (mem_we) begin
         ram[mem_addr] <= mem_din;
      end
      mem_dout <= ram[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      nchk++;
      assert (got === exp) npass++;
      else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic ram_all(input string tag, input logic [1:0] v);
      int bad;
      bad = 0;
      for (int i = 0; i < 8192; i++) if (ram[i] !== v) bad++;
      chk(tag, 16'(bad), 16'd0);
   endtask

   initial begin
      nchk = 0; npass = 0;
      ram_fill = 1'b1;
      reset = 1'b0;
      vid_req = 1'b1; vid_hpos = 7'd9; vid_vpos = 6'd1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd6; cpu_vpos = 6'd2; cpu_pixeli = 2'd0;
      clr_start = 1'b0; clr_value = 2'd0;

      // Reset with both requesters asking
      tick(); ram_fill = 1'b0;
      tick();
      chk("rst_outs", {mem_addr, mem_we, mem_din}, 16'd0);
      chk("rst_rsp", {vid_pixel, vid_valid, cpu_pixelo, cpu_ack, clr_busy}, 16'd0);
      chk("rst_starve", 16'(dut.starve_cnt), 16'd0);
      reset = 1'b1;
      tick(); chk("first_gnt_vid", 16'(mem_addr), 16'd137);
      chk("first_gnt_rd", 16'(mem_we), 16'd0);
      tick(); chk("second_gnt_cpu", 16'(mem_addr), 16'd262);
      tick(); chk("vid_valid_n2", {vid_valid, vid_pixel, cpu_ack}, {13'd0, 1'b1, 2'd1, 1'b0});
      vid_req = 1'b0;
      tick(); chk("cpu_ack_n2", {cpu_ack, cpu_pixelo, vid_valid}, {13'd0, 1'b1, 2'd2, 1'b0});
      cpu_req = 1'b0;
      tick();

      // CPU write (5,7)=3 then read it back
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_hpos = 7'd5; cpu_vpos = 6'd7; cpu_pixeli = 2'd3;
      tick(); chk("wr_bus", {mem_we, mem_addr, mem_din}, {1'b1, 13'd901, 2'd3});
      tick(); chk("wr_we_once", 16'(mem_we), 16'd0);
      tick(); chk("wr_ack", {cpu_ack, cpu_pixelo}, {13'd0, 1'b1, 2'd2});
      cpu_we = 1'b0;
      tick(); chk("rd_bus", {mem_we, mem_addr}, {2'd0, 13'd901});
      tick(); chk("rd_no_ack_yet", 16'(cpu_ack), 16'd0);
      tick(); chk("rd_back", {cpu_ack, cpu_pixelo}, {13'd0, 1'b1, 2'd3});
      cpu_req = 1'b0;
      tick();

      // Continuous video with CPU arriving on a video grant edge
      vid_req = 1'b1; vid_hpos = 7'd3; vid_vpos = 6'd4;
      tick(); chk("sv_gnt0", 16'(mem_addr), 16'd515);
      tick();
      tick(); chk("sv_valid0", {vid_valid, vid_pixel}, {13'd0, 1'b1, 2'd3});
      vid_hpos = 7'd20; vid_vpos = 6'd1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd10; cpu_vpos = 6'd0;
      tick(); chk("sv_vid_wins", 16'(mem_addr), 16'd148);
      chk("sv_starve1", 16'(dut.starve_cnt), 16'd1);
      tick(); chk("sv_cpu_gnt", 16'(mem_addr), 16'd10);
      chk("sv_starve0", 16'(dut.starve_cnt), 16'd0);
      tick(); chk("sv_valid1", {vid_valid, vid_pixel}, {13'd0, 1'b1, 2'd0});
      vid_hpos = 7'd1; vid_vpos = 6'd0;
      tick(); chk("sv_cpu_ack", {cpu_ack, cpu_pixelo}, {13'd0, 1'b1, 2'd2});
      chk("sv_vid_regnt", 16'(mem_addr), 16'd1);
      cpu_req = 1'b0;
      tick();
      tick(); chk("sv_valid2", {vid_valid, vid_pixel}, {13'd0, 1'b1, 2'd1});
      vid_req = 1'b0;
      tick();

      // Reset during an outstanding CPU read drops the ack
      cpu_req = 1'b1; cpu_hpos = 7'd6; cpu_vpos = 6'd2;
      tick(); chk("mr_gnt", 16'(mem_addr), 16'd262);
      reset = 1'b0;
      tick(); chk("mr_rst", {cpu_ack, mem_we, mem_addr}, 16'd0);
      tick(); chk("mr_noack", 16'(cpu_ack), 16'd0);
      reset = 1'b1; cpu_req = 1'b0;
      tick(); chk("mr_noack_after", 16'(cpu_ack), 16'd0);
      tick();

`ifdef VRAM_ARB_CLEAR_EN
      begin
         int n, busy, early, ng, bad_t, bad_p;
         logic vg, vgp1, vgp2;

         // Clear to 2, CPU read waits for the sweep to finish
         clr_start = 1'b1; clr_value = 2'd2;
         tick(); chk("clr_busy_rise", 16'(clr_busy), 16'd1);
         clr_start = 1'b0;
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd10; cpu_vpos = 6'd0;
         n = 0; busy = 1; early = 0;
         while (!cpu_ack && n < 9000) begin
            tick(); n++;
            if (clr_busy) busy++;
            if (cpu_ack && clr_busy) early++;
         end
         chk("clr_busy_len", 16'(busy), 16'd8192);
         chk("clr_cpu_ack_cyc", 16'(n), 16'd8195);
         chk("clr_cpu_early", 16'(early), 16'd0);
         chk("clr_cpu_pix", 16'(cpu_pixelo), 16'd2);
         cpu_req = 1'b0;
         tick();
         ram_all("clr_fill2", 2'd2);

         // Clear to 1 with video reading (64,62) for the first 40 cycles
         clr_start = 1'b1; clr_value = 2'd1;
         vid_req = 1'b1; vid_hpos = 7'd64; vid_vpos = 6'd62;
         tick();
         clr_start = 1'b0;
         vg = !mem_we && mem_addr == 13'd8000;
         ng = vg ? 1 : 0; vgp1 = vg; vgp2 = 1'b0;
         busy = clr_busy ? 1 : 0; n = 0; bad_t = 0; bad_p = 0;
         while (clr_busy && n < 9500) begin
            tick(); n++;
            vg = !mem_we && mem_addr == 13'd8000;
            if (vid_valid !== vgp2) bad_t++;
            if (vid_valid && vid_pixel !== 2'd2) bad_p++;
            if (vg) ng++;
            vgp2 = vgp1; vgp1 = vg;
            if (clr_busy) busy++;
            if (n == 40) vid_req = 1'b0;
         end
         for (int k = 0; k < 2; k++) begin
            tick();
            if (vid_valid !== vgp2) bad_t++;
            vgp2 = vgp1; vgp1 = 1'b0;
         end
         chk("cv_vid_grants", 16'(ng), 16'd14);
         chk("cv_valid_timing", 16'(bad_t), 16'd0);
         chk("cv_vid_pixel", 16'(bad_p), 16'd0);
         chk("cv_busy_len", 16'(busy), 16'd8205);
         ram_all("cv_fill1", 2'd1);

         // CPU read granted on the clr_start edge completes; reset mid-sweep aborts
         clr_start = 1'b1; clr_value = 2'd3;
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd3; cpu_vpos = 6'd0;
         tick(); chk("rs_cpu_gnt", {clr_busy, mem_we, mem_addr}, {1'b1, 1'b0, 14'd3});
         clr_start = 1'b0;
         tick(); chk("rs_sweep0", {mem_we, mem_addr, mem_din}, {1'b1, 13'd0, 2'd3});
         tick(); chk("rs_cpu_ack", {cpu_ack, cpu_pixelo}, {13'd0, 1'b1, 2'd1});
         chk("rs_sweep1", 16'(mem_addr), 16'd1);
         cpu_req = 1'b0;
         tick(); chk("rs_sweep2", 16'(mem_addr), 16'd2);
         reset = 1'b0;
         tick(); chk("rs_abort", {clr_busy, cpu_ack, mem_we}, 16'd0);
         reset = 1'b1;
         clr_start = 1'b1; clr_value = 2'd2;
         tick(); chk("rs_restart_busy", 16'(clr_busy), 16'd1);
         clr_start = 1'b0;
         tick(); chk("rs_restart_addr0", {mem_we, mem_addr, mem_din}, {1'b1, 13'd0, 2'd2});
      end
`else
      // No clear engine: clr_start is ignored and the CPU is served at once
      clr_start = 1'b1; clr_value = 2'd2;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd5; cpu_vpos = 6'd7;
      tick(); chk("nc_busy", 16'(clr_busy), 16'd0);
      chk("nc_cpu_gnt", {mem_we, mem_addr}, {3'd0, 13'd901});
      clr_start = 1'b0;
      tick(); chk("nc_no_clear_wr", 16'(mem_we), 16'd0);
      tick(); chk("nc_cpu_ack", {cpu_ack, cpu_pixelo, clr_busy}, {12'd0, 1'b1, 2'd3, 1'b0});
      cpu_req = 1'b0;
      tick(); chk("nc_idle", {mem_we, clr_busy}, 16'd0);
`endif

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port 128x64x2-bit VRAM between three requesters: video scan-out, CPU pixel read/write, and a hardware screen-clear engine. It sits between `cpu`, the video driver and a single-port `vram` instance. That removes the second VRAM port from the memory. Video scan-out has priority, bounded by a CPU anti-starvation rule.

## Interface
Parameters:
- STARVE_LIMIT, 3: consecutive cycles a waiting eligible CPU request may lose to video before it is forced through (1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- vid_req  in  1  video read request, held until vid_valid
- vid_hpos  in  7  video x
- vid_vpos  in  6  video y
- vid_pixel  out  2  read data, valid while vid_valid
- vid_valid  out  1  one-cycle completion pulse
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_hpos  in  7  CPU x
- cpu_vpos  in  6  CPU y
- cpu_pixeli  in  2  write data
- cpu_pixelo  out  2  read data, valid while cpu_ack
- cpu_ack  out  1  one-cycle completion pulse (reads and writes)
- clr_start  in  1  one-cycle pulse: fill VRAM with clr_value
- clr_value  in  2  fill colour, sampled with clr_start
- clr_busy  out  1  clear in progress
- mem_addr  out  13  {vpos, hpos} to VRAM
- mem_we  out  1  VRAM write strobe
- mem_din  out  2  VRAM write data
- mem_dout  in  2  VRAM read data, one cycle after address

## Operation
- Eligibility:
  - A requester is eligible when its req is high and it has no transaction outstanding.
  - Outstanding runs from its grant edge through the edge that raises its ack/valid, inclusive.
  - The CPU is ineligible while clr_busy is high.
- Arbitration at each edge picks at most one winner:
  - CPU, if eligible and starve_cnt == STARVE_LIMIT.
  - Otherwise video, if eligible.
  - Otherwise CPU, if eligible.
  - Otherwise the clear engine, if busy.
  - Otherwise idle.
- starve_cnt (4 bits):
  - Increments when the CPU is eligible and video wins.
  - Clears when the CPU wins or the CPU is not eligible.
- Winner's address/we/din are registered onto mem_* at the grant edge. mem_we is high for exactly one cycle per write grant and 0 on idle and read cycles.
- Read completion: mem_dout is captured into vid_pixel / cpu_pixelo, and the ack/valid pulse is raised, at grant edge + 2.
- CPU write completion: cpu_ack pulses at grant edge + 2; cpu_pixelo is unchanged.
- The requester may change req/address in its ack cycle. Those values are sampled at the next edge.
- Clear engine:
  - States IDLE and SWEEP.
  - clr_start in IDLE latches clr_value, zeroes the 13-bit sweep address, enters SWEEP and sets clr_busy.
  - Each clear grant writes clr_value at the sweep address, then increments it.
  - The grant that writes address 8191 returns to IDLE, and clr_busy falls at that edge.
  - clr_start in SWEEP is ignored.
- A CPU request outstanding at clr_start completes normally. New CPU requests wait until clr_busy is low.
- Reset mid-operation aborts everything: outstanding transactions are dropped with no ack, and the clear sweep is abandoned.
- Reset values:
  - mem_addr, mem_din, vid_pixel, cpu_pixelo: 0.
  - mem_we, vid_valid, cpu_ack, clr_busy: 0.
  - starve_cnt, outstanding flags, sweep address: 0.
  - Clear FSM: IDLE.

## Timing
- Request sampled at edge N → mem_* driven after edge N → VRAM reads at N+1 → ack/valid and data registered at N+2.
- Minimum per-requester period: 3 cycles (grant N, ack N+2, next grant N+3).
- Video alone issues one access per 3 cycles; the CPU can fill the idle slots.
- Worst-case CPU wait against continuous video: STARVE_LIMIT cycles after becoming eligible.
- A full clear takes 8192 clear grants. It completes in 8192 cycles with no other traffic, and longer otherwise.
- At most one mem_* transaction per cycle; reads and writes never overlap on the bus.

## Configuration
- VRAM_ARB_CLEAR_EN defined: the clear engine is present as described.
- Undefined: no clear engine is built. clr_start and clr_value are ignored, clr_busy is tied 0, and the CPU is never blocked by clearing.

## Test plan
- Reset with vid_req = cpu_req = 1 → all outputs 0 while reset = 0. First grant goes to video at the first edge after release; vid_valid pulses 2 cycles later.
- CPU write (5,7) = 2'b11, then CPU read (5,7) → mem_we pulse with mem_addr = {6'd7, 7'd5} and mem_din = 3; the read returns cpu_pixelo = 3 with cpu_ack.
- vid_req held high continuously with a new address each valid, cpu_req raised → CPU granted within STARVE_LIMIT (3) cycles; starve_cnt returns to 0.
- clr_start with clr_value = 2, then cpu_req → clr_busy high for 8192 cycles if no video. Every address reads back 2. The CPU is acked only after clr_busy falls.
- Video traffic during a clear → every vid_valid arrives 2 cycles after grant; the clear sweep pauses and resumes without skipping addresses.
- Reset asserted mid-clear and mid-CPU-read → clr_busy = 0 and no cpu_ack. A new clr_start after release restarts from address 0.
